// File: rtl/axi_tdd_ng_pkg.sv
// Shared constants for the TDD engine sync logic.
package axi_tdd_ng_pkg;

  localparam int SYNC_CDC_STAGES   = 2;
  localparam int SYNC_STATUS_WIDTH = 32;

endpackage

// File: rtl/axi_tdd_ng_sync_edge.sv
// Optional two-flop synchronizer followed by a rising-edge detector.
module axi_tdd_ng_sync_edge
  import axi_tdd_ng_pkg::*;
#(
  parameter int CDC = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic level;
  logic hist;

  generate
    if (CDC != 0) begin : g_cdc
      logic [SYNC_CDC_STAGES-1:0] meta;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          meta <= '0;
        end else begin
          meta <= {meta[SYNC_CDC_STAGES-2:0], din};
        end
      end

      assign level = meta[SYNC_CDC_STAGES-1];
    end else begin : g_direct
      assign level = din;
    end
  endgenerate

  // History runs unconditionally so a level that is already high never
  // looks like an edge when its consumer is enabled later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist <= 1'b0;
    end else begin
      hist <= level;
    end
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/axi_tdd_ng_sync_gen.sv
// Merges external, software and periodic sync sources into the tdd_sync strobe.
module axi_tdd_ng_sync_gen
  import axi_tdd_ng_pkg::*;
#(
  parameter int SYNC_COUNT_WIDTH  = 64,
  parameter int SYNC_EXTERNAL_CDC = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync_int,
  input  logic                         tdd_sync_ext,
  input  logic                         tdd_sync_soft,
  input  logic [SYNC_COUNT_WIDTH-1:0]  tdd_sync_period,
  input  logic                         sync_in,
  output logic                         tdd_sync,
  output logic [SYNC_STATUS_WIDTH-1:0] tdd_sync_cnt
);

  localparam logic [SYNC_COUNT_WIDTH-1:0]  PERIOD_ONE = 1;
  localparam logic [SYNC_STATUS_WIDTH-1:0] STATUS_ONE = 1;

  logic                         ext_rise;
  logic                         ext_req;
  logic                         soft_req;
  logic                         int_req;
  logic                         counting;
  logic [SYNC_COUNT_WIDTH-1:0]  period_cnt;
  logic [SYNC_STATUS_WIDTH-1:0] sync_cnt;

  axi_tdd_ng_sync_edge #(
    .CDC(SYNC_EXTERNAL_CDC)
  ) u_ext_edge (
    .clk   (clk),
    .resetn(resetn),
    .din   (sync_in),
    .rise  (ext_rise)
  );

  axi_tdd_ng_sync_edge #(
    .CDC(0)
  ) u_soft_edge (
    .clk   (clk),
    .resetn(resetn),
    .din   (tdd_sync_soft),
    .rise  (soft_req)
  );

  assign ext_req  = ext_rise & tdd_sync_ext;
  assign counting = tdd_enable & tdd_sync_int & (tdd_sync_period != '0);
  // >= lets a shrunk period fire immediately instead of waiting for a wrap.
  assign int_req  = counting & (period_cnt >= (tdd_sync_period - PERIOD_ONE));

  // External and soft events realign the periodic grid to themselves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_cnt <= '0;
    end else if (!counting || int_req || ext_req || soft_req) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdd_sync <= 1'b0;
    end else begin
      tdd_sync <= tdd_enable & (ext_req | soft_req | int_req);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_cnt <= '0;
    end else if (tdd_sync) begin
      sync_cnt <= sync_cnt + STATUS_ONE;
    end
  end

  assign tdd_sync_cnt = sync_cnt;

endmodule

// File: tb/tb_axi_tdd_ng_sync_gen.sv
// Randomized and directed bench for axi_tdd_ng_sync_gen against an edge-indexed reference model.
module tb_axi_tdd_ng_sync_gen;

  localparam int W   = 64;
  localparam int CDC = 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tdd_enable = 1'b0;
  logic          tdd_sync_int = 1'b0;
  logic          tdd_sync_ext = 1'b0;
  logic          tdd_sync_soft = 1'b0;
  logic [W-1:0]  tdd_sync_period = '0;
  logic          sync_in = 1'b0;
  logic          tdd_sync;
  logic [31:0]   tdd_sync_cnt;

  axi_tdd_ng_sync_gen #(
    .SYNC_COUNT_WIDTH (W),
    .SYNC_EXTERNAL_CDC(CDC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .tdd_enable     (tdd_enable),
    .tdd_sync_int   (tdd_sync_int),
    .tdd_sync_ext   (tdd_sync_ext),
    .tdd_sync_soft  (tdd_sync_soft),
    .tdd_sync_period(tdd_sync_period),
    .sync_in        (sync_in),
    .tdd_sync       (tdd_sync),
    .tdd_sync_cnt   (tdd_sync_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: every active edge gets an index; the periodic source fires
  // when at least P edges have passed since the grid was last anchored.
  logic [32:0] exp_q[$];
  logic [2:0]  pin_hist = '0;
  logic        soft_prev = 1'b0;
  logic        prev_exp = 1'b0;
  longint      edge_n = 0;
  longint      anchor = 0;
  logic [31:0] m_cnt = '0;

  always @(posedge clk) begin
    logic run_int, ext_ev, soft_ev, int_ev, exp_s;
    if (!resetn) begin
      pin_hist  = '0;
      soft_prev = 1'b0;
      prev_exp  = 1'b0;
      anchor    = edge_n;
      m_cnt     = '0;
    end else begin
      edge_n++;
      run_int = tdd_enable && tdd_sync_int && (tdd_sync_period != '0);
      ext_ev  = tdd_sync_ext && pin_hist[1] && !pin_hist[2];
      soft_ev = tdd_sync_soft && !soft_prev;
      int_ev  = run_int && (64'(edge_n - anchor) >= tdd_sync_period);
      exp_s   = tdd_enable && (ext_ev || soft_ev || int_ev);
      if (!run_int || ext_ev || soft_ev || int_ev) anchor = edge_n;
      pin_hist  = {pin_hist[1:0], sync_in};
      soft_prev = tdd_sync_soft;
      if (prev_exp) m_cnt++;
      prev_exp = exp_s;
      exp_q.push_back({exp_s, m_cnt});
    end
  end

  // scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (!resetn) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_tdd_sync", 64'(tdd_sync), 64'(e[32]));
      check("sb_tdd_sync_cnt", 64'(tdd_sync_cnt), 64'(e[31:0]));
    end
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic en, input logic int_en, input logic ext_en, input int period);
    tdd_enable      = en;
    tdd_sync_int    = int_en;
    tdd_sync_ext    = ext_en;
    tdd_sync_period = W'(period);
  endtask

  task automatic wait_sync(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (tdd_sync) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] c0;
    logic [2:0]  seen;
    int          n;

    run(3);
    check("reset_sync", 64'(tdd_sync), 64'd0);
    check("reset_cnt", 64'(tdd_sync_cnt), 64'd0);
    resetn = 1'b1;
    run(2);

    // periodic source, period 5
    c0 = tdd_sync_cnt;
    set_cfg(1, 1, 0, 5);
    run(21);
    check("int_p5_cnt", 64'(tdd_sync_cnt - c0), 64'd4);
    set_cfg(1, 1, 0, 0);
    run(2);
    c0 = tdd_sync_cnt;
    run(20);
    check("int_p0_cnt", 64'(tdd_sync_cnt - c0), 64'd0);

    // software source held high
    set_cfg(1, 0, 0, 0);
    run(2);
    c0 = tdd_sync_cnt;
    tdd_sync_soft = 1'b1;
    run(1);
    check("soft_latency", 64'(tdd_sync), 64'd1);
    run(9);
    tdd_sync_soft = 1'b0;
    run(3);
    check("soft_once_cnt", 64'(tdd_sync_cnt - c0), 64'd1);

    // external source through the synchronizer
    c0 = tdd_sync_cnt;
    set_cfg(1, 0, 1, 0);
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(1);
      seen[i] = tdd_sync;
    end
    check("ext_latency", 64'(seen), 64'b100);
    run(1);
    sync_in = 1'b0;
    run(5);
    check("ext_once_cnt", 64'(tdd_sync_cnt - c0), 64'd1);
    set_cfg(1, 0, 0, 0);
    c0 = tdd_sync_cnt;
    sync_in = 1'b1;
    run(4);
    sync_in = 1'b0;
    run(5);
    check("ext_disabled_cnt", 64'(tdd_sync_cnt - c0), 64'd0);

    // realignment of the periodic grid to an external event
    set_cfg(1, 1, 1, 8);
    run(1);
    sync_in = 1'b1;
    wait_sync(10, n);
    check("realign_ext_seen", 64'(n > 0), 64'd1);
    sync_in = 1'b0;
    wait_sync(20, n);
    check("realign_gap", 64'(n), 64'd8);

    // period shrink mid-count
    set_cfg(1, 0, 0, 0);
    run(2);
    set_cfg(1, 1, 0, 10);
    run(6);
    tdd_sync_period = W'(4);
    run(1);
    check("shrink_next", 64'(tdd_sync), 64'd1);
    wait_sync(10, n);
    check("shrink_gap", 64'(n), 64'd4);

    // enable low gates every source
    set_cfg(0, 1, 1, 1);
    run(2);
    c0 = tdd_sync_cnt;
    for (int i = 0; i < 12; i++) begin
      sync_in       = i[1];
      tdd_sync_soft = i[0];
      run(1);
    end
    sync_in = 1'b0;
    tdd_sync_soft = 1'b0;
    run(4);
    check("gated_cnt", 64'(tdd_sync_cnt - c0), 64'd0);

    // randomized mix of all sources
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) tdd_enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) tdd_sync_int = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) tdd_sync_ext = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) tdd_sync_period = W'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) sync_in = ~sync_in;
      if ($urandom_range(0, 7) == 0) tdd_sync_soft = ~tdd_sync_soft;
      run(1);
    end

    // status counter wrap
    set_cfg(1, 0, 0, 0);
    sync_in = 1'b0;
    tdd_sync_soft = 1'b0;
    run(6);
    #2;
    force dut.sync_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.sync_cnt;
    @(negedge clk);
    tdd_sync_soft = 1'b1;
    run(3);
    tdd_sync_soft = 1'b0;
    check("cnt_wrap", 64'(tdd_sync_cnt), 64'd0);

    // asynchronous reset in the middle of a clock phase
    set_cfg(1, 1, 0, 1);
    run(5);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_sync", 64'(tdd_sync), 64'd0);
    check("async_rst_cnt", 64'(tdd_sync_cnt), 64'd0);
    run(2);
    resetn = 1'b1;
    set_cfg(1, 1, 0, 3);
    run(20);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_sync_gen.md
# axi_tdd_ng_sync_gen

Produces the single-cycle `tdd_sync` strobe consumed by the TDD frame counter. It merges three sync sources into one qualified pulse stream gated by the TDD enable: an external pin, a software strobe, and an internal periodic generator. It sits between the TDD register map / external sync pin and the counter state machine, and also keeps a running count of emitted syncs for status readback.

## Interface
- `SYNC_COUNT_WIDTH`, 64: width of the internal period counter and of `tdd_sync_period`.
- `SYNC_EXTERNAL_CDC`, 1: 1 = `sync_in` is asynchronous and goes through the synchronizer; 0 = `sync_in` is already in the `clk` domain.
- `clk`  in  1  block clock; all logic runs in this single domain.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `tdd_enable`  in  1  master enable; 0 suppresses all output pulses and clears the period counter.
- `tdd_sync_int`  in  1  enables the internal periodic source.
- `tdd_sync_ext`  in  1  enables the external source.
- `tdd_sync_soft`  in  1  software sync level from the register map; its rising edge requests one pulse.
- `tdd_sync_period`  in  SYNC_COUNT_WIDTH  internal period in clocks; 0 disables the internal source.
- `sync_in`  in  1  external sync pin; its rising edge requests one pulse.
- `tdd_sync`  out  1  qualified sync strobe, one clock wide.
- `tdd_sync_cnt`  out  32  number of `tdd_sync` pulses emitted, wraps modulo 2^32.

## Operation
- **External path.**
  - With `SYNC_EXTERNAL_CDC=1`: two metastability flops feed an edge-history flop.
  - With `SYNC_EXTERNAL_CDC=0`: only the edge-history flop is used.
  - `ext_req` = synced level & ~history & `tdd_sync_ext`.
  - The flops run regardless of enables, so a level already high when the source is enabled produces no request.
- **Soft path.** `soft_req` = `tdd_sync_soft` & ~`tdd_sync_soft` delayed one clock. Holding the bit high yields exactly one request.
- **Internal path.**
  - `period_cnt` counts only while `tdd_enable` & `tdd_sync_int` & (`tdd_sync_period` != 0); otherwise it is held at 0.
  - `int_req` = counting & (`period_cnt` >= `tdd_sync_period` - 1). On `int_req`, `period_cnt` reloads 0.
  - Using `>=` means that lowering the period mid-count fires on the next clock instead of waiting for a wrap.
- **Realignment.** Any `ext_req` or `soft_req` reloads `period_cnt` to 0, so the periodic grid aligns to the latest external or soft event.
- **Merge.**
  - `tdd_sync` <= `tdd_enable` & (`ext_req` | `soft_req` | `int_req`).
  - Simultaneous requests collapse into one pulse.
  - Requests while `tdd_enable`=0 are discarded, never queued.
- **Status.** `tdd_sync_cnt` increments by 1 on each clock where `tdd_sync`=1 and wraps from 0xFFFFFFFF to 0. It is cleared only by `resetn`.

## Timing
- **Reset.** `resetn` low clears all flops asynchronously. Outputs: `tdd_sync`=0, `tdd_sync_cnt`=0, and `period_cnt`=0. Release is synchronous to `clk` via the upstream reset bridge.
- **Soft latency.** `tdd_sync_soft` first sampled high at edge k → `tdd_sync`=1 for the cycle after edge k.
- **External latency, `SYNC_EXTERNAL_CDC=1`.** `sync_in` high first sampled at edge k → `tdd_sync` high after edge k+2, i.e. 3 clocks.
- **External latency, `SYNC_EXTERNAL_CDC=0`.** 1 clock.
- **Internal cadence.** For period P>=1, pulses are spaced exactly P clocks apart. P=1 gives `tdd_sync` continuously high, one pulse per clock. The first pulse arrives P clocks after counting starts.
- **Back-to-back requests.** Requests on consecutive clocks produce `tdd_sync` high on consecutive clocks. There is no minimum gap.
- **Enable drop.** `tdd_enable` falling at edge k: `tdd_sync`=0 after edge k, and `period_cnt`=0.
- **Reset mid-count.** The period restarts from 0 once reset is released.

## Structure
- Add to `axi_tdd_ng_pkg`:
  - `localparam SYNC_CDC_STAGES = 2`;
  - `localparam SYNC_STATUS_WIDTH = 32`.
- Sub-module `axi_tdd_ng_sync_edge` (parameter `CDC`): synchronizer plus rising-edge detector. Instanced once for `sync_in` with `CDC=SYNC_EXTERNAL_CDC` and once for `tdd_sync_soft` with `CDC=0`.
- Period counter, merge and status counter live in the top module.

## Test plan
- Internal source: enable=1, int=1, period=5 → `tdd_sync` pulses every 5 clocks, `tdd_sync_cnt`=4 after 20 clocks. Period=0 → no pulses.
- Soft source: hold `tdd_sync_soft` high for 10 clocks → exactly one pulse, 1 clock after the first sample, and `tdd_sync_cnt` +1.
- External source with CDC=1: 4-clock pulse on `sync_in` → one `tdd_sync` pulse 3 clocks after the first sample. With ext=0 → none.
- Realignment: period=8; an external request at `period_cnt`=3 → next internal pulse 8 clocks after the external one. Soft and internal requests in the same clock → a single pulse, count +1.
- Period shrink: at `period_cnt`=6, change period 10→4 → pulse on the next clock, then every 4 clocks.
- Gating and reset:
  - `tdd_enable`=0 with all sources firing → no pulses, count unchanged.
  - Assert `resetn` mid-period → `tdd_sync`=0 and `tdd_sync_cnt`=0 immediately, without waiting for a clock edge.
  - Counter wrap: preload via force to 0xFFFFFFFF, one pulse → 0.
